// File: rtl/l5_ram_master.sv
// Initiator for the L5 RAM: takes burst commands, streams write words in and
// read words out, one RAM access per clock with a wrapping word address.
module l5_ram_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              beat, issue, last;

    assign last  = (count == '0);
    assign beat  = (state == WR) && wr_valid;
    // A read issues only when the output register is free or being drained.
    assign issue = (state == RD) && (!rd_valid || rd_ready);

    assign ram_cs = beat | issue;
    assign ram_we = beat;
    assign ram_oe = issue;
    assign ram_a  = addr;
    assign ram_di = wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = cmd_write ? WR : RD;
            end
            WR: begin
                wr_ready = 1'b1;
                if (beat && last) state_nxt = IDLE;
            end
            RD: begin
                if (issue && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            count    <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= (beat | issue) && last;
            if (state == IDLE && cmd_valid) begin
                addr  <= cmd_addr;
                count <= cmd_len;
            end else if (beat | issue) begin
                addr  <= addr + 1'b1;
                count <= count - 1'b1;
            end
            if (issue) begin
                rd_data  <= ram_dout;
                rd_valid <= 1'b1;
                rd_last  <= last;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l5_ram_master.sv
// Bench for l5_ram_master: behavioural RAM, directed bursts, and a scoreboard
// monitor that checks RAM writes, read addresses and returned read words.
module tb_l5_ram_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b1, rd_last, done;
    logic [31:0] rd_data;
    logic [7:0]  ram_a;
    logic        ram_cs, ram_oe, ram_we;
    logic [31:0] ram_di, ram_dout;

    always #5 clk = ~clk;

    l5_ram_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .done(done),
        .ram_a(ram_a), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_di(ram_di), .ram_dout(ram_dout)
    );

    // Behavioural 256x32 RAM, preloaded with a recognisable pattern.
    logic [31:0] ram [256];
    bit          ram_init;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hDEAD0000 | i;
            ram_init <= 1'b1;
        end else if (ram_cs && ram_we) begin
            ram[ram_a] <= ram_di;
        end
    end
    assign ram_dout = (ram_cs && ram_oe) ? ram[ram_a] : 32'h0;

    logic [31:0] refm [256];
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_ra[$];
    logic [32:0] exp_rd[$];
    int checks = 0, errors = 0;
    int rd_count = 0, done_seen = 0, done_exp = 0;

    function automatic void chk(string name, logic [39:0] act, logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_cs && ram_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", {ram_a, ram_di}, 40'h0);
                else chk("ram_write", {ram_a, ram_di}, exp_wr.pop_front());
                chk("we_oe_exclusive", ram_oe, 1'b0);
            end
            if (ram_cs && ram_oe) begin
                if (exp_ra.size() == 0) chk("unexpected_read", ram_a, 8'h0);
                else chk("ram_read_addr", ram_a, exp_ra.pop_front());
            end
            if (ram_cs) chk("strobe_kind", ram_we ^ ram_oe, 1'b1);
            if (prev_stall) begin
                chk("stall_rd_valid", rd_valid, 1'b1);
                chk("stall_rd_hold", rd_data, prev_data);
            end
            if (rd_valid && !rd_ready) chk("stall_no_cs", ram_cs, 1'b0);
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) chk("unexpected_rd", {rd_last, rd_data}, 33'h0);
                else chk("rd_word", {rd_last, rd_data}, exp_rd.pop_front());
                rd_count++;
            end
            if (done) done_seen++;
            prev_stall <= rd_valid && !rd_ready;
            prev_data  <= rd_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [3:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("cmd_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] len,
                            input logic [31:0] base, input int gap);
        send_cmd(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [7:0] wa;
            wa = a + 8'(i);
            for (int g = 0; g < gap; g++) begin
                wr_valid = 1'b0;
                @(negedge clk); chk("gap_cmd_ready", cmd_ready, 1'b0);
                @(posedge clk); #1;
            end
            wr_valid = 1'b1; wr_data = base + i;
            refm[wa] = base + i;
            exp_wr.push_back({wa, base + 32'(i)});
            @(negedge clk);
            chk("wr_ready", wr_ready, 1'b1);
            chk("busy_cmd_ready", cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        done_exp++;
        chk("wr_done_pulse", done, 1'b1);
        chk("wr_idle_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        chk("wr_done_clear", done, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len,
                           input int stall_at, input int stall_len);
        int base = rd_count, cyc = 0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [7:0] ra;
            ra = a + 8'(i);
            exp_ra.push_back(ra);
            exp_rd.push_back({i == int'(len), refm[ra]});
        end
        rd_ready = 1'b1;
        send_cmd(1'b0, a, len);
        while (rd_count < base + int'(len) + 1 && cyc < 100) begin
            @(posedge clk); cyc++;
            if (stall_len > 0 && rd_count == base + stall_at) begin
                #1 rd_ready = 1'b0;
                repeat (stall_len) @(posedge clk);
                cyc += stall_len;
                #1 rd_ready = 1'b1;
            end
        end
        chk("rd_latency", 32'(cyc), 32'(int'(len) + 2 + stall_len));
        done_exp++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = 32'hDEAD0000 | i;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", ram_cs, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_write(8'h10, 4'd3, 32'h000000A0, 0);
        do_read(8'h10, 4'd3, 0, 0);
        do_write(8'hFE, 4'd3, 32'h000000D0, 0);
        do_read(8'hFE, 4'd3, 0, 0);
        do_read(8'h10, 4'd7, 2, 3);
        do_write(8'h80, 4'd5, 32'h000000C0, 2);
        do_read(8'h80, 4'd5, 0, 0);

        // Abort a len-7 write after two beats.
        send_cmd(1'b1, 8'h40, 4'd7);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 32'hE0 + i;
            refm[8'h40 + i] = 32'hE0 + i;
            exp_wr.push_back({8'(8'h40 + i), 32'(32'hE0 + i)});
            @(posedge clk); #1;
        end
        wr_data = 32'hE2;
        #1;
        chk("pre_abort_cs", {ram_cs, ram_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {ram_cs, ram_we, ram_oe}, 3'b000);
        chk("abort_idle", {cmd_ready, wr_ready}, 2'b10);
        wr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(8'h40, 4'd7, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("ra_queue_empty", exp_ra.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
